i2s_tdm_clock_gen: RTL and testbench

Parametrised I2S/TDM master clock generator: divides the system clock into a bit clock (`sck_o`), derives a word-select / frame-sync (`ws_o`) for any even slot count and slot width, and emits single-cycle edge and frame strobes for the serialiser/deserialiser. Supports runtime start/stop on frame boundaries and two WS styles: classic I2S 50 % word select and DSP/TDM one-bit frame pulse. It sits between the system clock domain and the I2S TX/RX datapath.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_sck_div.sv | 51 +++++
 rtl/i2s_tdm_clock_gen.sv | 146 ++++++++++++++
 tb/tb_i2s_tdm_clock_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S/TDM types: word-select style and generator state, used by the
// clock generator and the TX/RX serialisers.
package i2s_pkg;

   typedef enum logic {
      WS_I2S   = 1'b0,   // 50 % word select, high for the upper half of the slots
      WS_PULSE = 1'b1    // one-bit frame sync ahead of slot 0
   } ws_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } i2s_state_e;

endpackage

// File: rtl/i2s_sck_div.sv
// Bit-clock divider: counts system clocks per SCK period and registers the
// bit clock plus its fall/rise strobes so they leave the block straight from flops.
module i2s_sck_div #(
   parameter int SCK_DIV = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,     // generator will be running in the next cycle
   input  logic clr_i,    // restart the SCK period from its falling edge
   output logic sck_o,
   output logic fall_o,
   output logic rise_o,
   output logic wrap_o    // last system clock of the current SCK period
);

   localparam int DIV_W = $clog2(SCK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCK_DIV / 2);

   logic [DIV_W-1:0] div_reg, div_next;
   logic             sck_reg, fall_reg, rise_reg;

   assign wrap_o = (div_reg == DIV_LAST);

   always_comb begin
      div_next = '0;
      if (en_i && !clr_i && !wrap_o) begin
         div_next = div_reg + DIV_W'(1);
      end
   end

   // Outputs are decoded from the next count so they line up with div_reg.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         div_reg  <= '0;
         sck_reg  <= 1'b0;
         fall_reg <= 1'b0;
         rise_reg <= 1'b0;
      end else begin
         div_reg  <= div_next;
         sck_reg  <= en_i && (div_next >= DIV_HALF);
         fall_reg <= en_i && (div_next == '0);
         rise_reg <= en_i && (div_next == DIV_HALF);
      end
   end

   assign sck_o  = sck_reg;
   assign fall_o = fall_reg;
   assign rise_o = rise_reg;

endmodule

// File: rtl/i2s_tdm_clock_gen.sv
// I2S/TDM master clock generator: SCK, WS/frame sync and edge/frame strobes.
// Define I2S_TDM_SLOT_IDX_EN to expose the slot_o/bit_o position ports.
module i2s_tdm_clock_gen
   import i2s_pkg::*;
#(
   parameter int SCK_DIV   = 8,
   parameter int SLOT_BITS = 32,
   parameter int NUM_SLOTS = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic ws_mode_i,
   output logic busy_o,
   output logic sck_o,
   output logic ws_o,
   output logic sck_fall_o,
   output logic sck_rise_o,
   output logic frame_start_o
`ifdef I2S_TDM_SLOT_IDX_EN
  ,output logic [$clog2(NUM_SLOTS)-1:0] slot_o,
   output logic [$clog2(SLOT_BITS)-1:0] bit_o
`endif
);

   localparam int SLOT_W = $clog2(NUM_SLOTS);
   localparam int BIT_W  = $clog2(SLOT_BITS);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
   localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(NUM_SLOTS / 2);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_BITS - 1);

   i2s_state_e        state_reg, state_next;
   ws_mode_e          mode_reg, mode_next;
   logic [SLOT_W-1:0] slot_reg, slot_next, slot_ahead;
   logic [BIT_W-1:0]  bit_reg, bit_next;
   logic              ws_reg, ws_next;
   logic              frame_start_reg, frame_start_next;
   logic              stop_reg, stop_next;
   logic              start, run_next, fall_event, last_new, div_wrap;

   function automatic logic [BIT_W-1:0] adv_bit(input logic [BIT_W-1:0] b);
      return (b == BIT_LAST) ? '0 : b + BIT_W'(1);
   endfunction

   function automatic logic [SLOT_W-1:0] adv_slot(input logic [SLOT_W-1:0] s,
                                                  input logic [BIT_W-1:0]  b);
      if (b != BIT_LAST) return s;
      return (s == SLOT_LAST) ? '0 : s + SLOT_W'(1);
   endfunction

   i2s_sck_div #(
      .SCK_DIV (SCK_DIV)
   ) u_sck_div (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (run_next),
      .clr_i  (start),
      .sck_o  (sck_o),
      .fall_o (sck_fall_o),
      .rise_o (sck_rise_o),
      .wrap_o (div_wrap)
   );

   // A pending stop lets the final lead-out bit finish before dropping to IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (en_i) state_next = RUN;
         RUN:     if (div_wrap && stop_reg) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign start      = (state_reg == IDLE) && en_i;
   assign run_next   = (state_next == RUN);
   assign fall_event = start || ((state_reg == RUN) && div_wrap && run_next);

   // Position and WS are advanced on the edge that raises sck_fall_o; WS looks
   // one bit ahead of the position that becomes current on that edge.
   always_comb begin
      slot_next        = slot_reg;
      bit_next         = bit_reg;
      ws_next          = ws_reg;
      mode_next        = mode_reg;
      stop_next        = stop_reg;
      frame_start_next = 1'b0;
      last_new         = 1'b0;
      slot_ahead       = '0;
      if (!run_next) begin
         slot_next = '0;
         bit_next  = '0;
         ws_next   = 1'b0;
         stop_next = 1'b0;
      end else if (fall_event) begin
         if (start) begin
            mode_next = ws_mode_e'(ws_mode_i);
            slot_next = SLOT_LAST;
            bit_next  = BIT_LAST;
         end else begin
            slot_next = adv_slot(slot_reg, bit_reg);
            bit_next  = adv_bit(bit_reg);
         end
         last_new         = (slot_next == SLOT_LAST) && (bit_next == BIT_LAST);
         slot_ahead       = adv_slot(slot_next, bit_next);
         frame_start_next = (slot_next == '0) && (bit_next == '0);
         if (last_new && !start && !en_i) begin
            stop_next = 1'b1;
            ws_next   = 1'b0;
         end else if (mode_next == WS_PULSE) begin
            ws_next = last_new;
         end else begin
            ws_next = (slot_ahead >= SLOT_HALF);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg       <= IDLE;
         mode_reg        <= WS_I2S;
         slot_reg        <= '0;
         bit_reg         <= '0;
         ws_reg          <= 1'b0;
         stop_reg        <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         mode_reg        <= mode_next;
         slot_reg        <= slot_next;
         bit_reg         <= bit_next;
         ws_reg          <= ws_next;
         stop_reg        <= stop_next;
         frame_start_reg <= frame_start_next;
      end
   end

   assign busy_o        = (state_reg == RUN);
   assign ws_o          = ws_reg;
   assign frame_start_o = frame_start_reg;

`ifdef I2S_TDM_SLOT_IDX_EN
   assign slot_o = slot_reg;
   assign bit_o  = bit_reg;
`endif

endmodule

// File: tb/tb_i2s_tdm_clock_gen.sv
// Scoreboard bench for i2s_tdm_clock_gen: three configurations (defaults I2S,
// 8x16 TDM pulse, SCK_DIV=2) with busy/WS/frame events checked against queues.
module tb_i2s_tdm_clock_gen;

   localparam int EV_BR  = 0;   // busy rise
   localparam int EV_WSR = 1;   // ws rise
   localparam int EV_WSF = 2;   // ws fall
   localparam int EV_FS  = 3;   // frame_start strobe
   localparam int EV_BF  = 4;   // busy fall

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   ev_t q0[$];
   ev_t q1[$];
   ev_t q2[$];

   logic [2:0] rst_n, en, mode;
   logic [2:0] busy, sck, ws, fall, rise, fs;
`ifdef I2S_TDM_SLOT_IDX_EN
   logic [0:0] slot_a; logic [4:0] bit_a;
   logic [2:0] slot_b; logic [3:0] bit_b;
   logic [0:0] slot_c; logic [1:0] bit_c;
`endif

   i2s_tdm_clock_gen #(.SCK_DIV(8), .SLOT_BITS(32), .NUM_SLOTS(2)) u_a (
      .clk_i (clk), .rst_ni (rst_n[0]), .en_i (en[0]), .ws_mode_i (mode[0]),
      .busy_o (busy[0]), .sck_o (sck[0]), .ws_o (ws[0]),
      .sck_fall_o (fall[0]), .sck_rise_o (rise[0]), .frame_start_o (fs[0])
`ifdef I2S_TDM_SLOT_IDX_EN
     ,.slot_o (slot_a), .bit_o (bit_a)
`endif
   );

   i2s_tdm_clock_gen #(.SCK_DIV(8), .SLOT_BITS(16), .NUM_SLOTS(8)) u_b (
      .clk_i (clk), .rst_ni (rst_n[1]), .en_i (en[1]), .ws_mode_i (mode[1]),
      .busy_o (busy[1]), .sck_o (sck[1]), .ws_o (ws[1]),
      .sck_fall_o (fall[1]), .sck_rise_o (rise[1]), .frame_start_o (fs[1])
`ifdef I2S_TDM_SLOT_IDX_EN
     ,.slot_o (slot_b), .bit_o (bit_b)
`endif
   );

   i2s_tdm_clock_gen #(.SCK_DIV(2), .SLOT_BITS(4), .NUM_SLOTS(2)) u_c (
      .clk_i (clk), .rst_ni (rst_n[2]), .en_i (en[2]), .ws_mode_i (mode[2]),
      .busy_o (busy[2]), .sck_o (sck[2]), .ws_o (ws[2]),
      .sck_fall_o (fall[2]), .sck_rise_o (rise[2]), .frame_start_o (fs[2])
`ifdef I2S_TDM_SLOT_IDX_EN
     ,.slot_o (slot_c), .bit_o (bit_c)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (cyc=%0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int d, input int kind, input int c);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic got(input int d, input int kind);
      ev_t e;
      int  found;
      found = 0;
      e.kind = -1;
      e.cyc  = -1;
      case (d)
         0:       if (q0.size() > 0) begin e = q0.pop_front(); found = 1; end
         1:       if (q1.size() > 0) begin e = q1.pop_front(); found = 1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); found = 1; end
      endcase
      total++;
      if (found == 0) begin
         bad++;
         $display("FAIL dut%0d_event: got kind=%0d cyc=%0d, want no event", d, kind, cyc);
      end else if (e.kind != kind || e.cyc != cyc) begin
         bad++;
         $display("FAIL dut%0d_event: got kind=%0d cyc=%0d, want kind=%0d cyc=%0d",
                  d, kind, cyc, e.kind, e.cyc);
      end else begin
         $display("ok dut%0d event kind=%0d cyc=%0d", d, kind, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic idle_check(input string name, input int d);
      int nz;
      nz = 0;
      for (int i = 0; i < 16; i++) begin
         nz += int'(sck[d] | ws[d] | busy[d] | fs[d] | fall[d] | rise[d]);
         @(negedge clk);
      end
      chk(name, nz, 0);
   endtask

   // Monitor: any busy/ws edge or frame strobe pops and checks the next expectation.
   logic [2:0] busy_p = '0;
   logic [2:0] ws_p   = '0;
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (busy[d] === 1'b1 && !busy_p[d]) got(d, EV_BR);
         if (ws[d] === 1'b1 && !ws_p[d])     got(d, EV_WSR);
         if (ws[d] === 1'b0 && ws_p[d])      got(d, EV_WSF);
         if (fs[d] === 1'b1)                 got(d, EV_FS);
         if (busy[d] === 1'b0 && busy_p[d])  got(d, EV_BF);
      end
      busy_p <= busy;
      ws_p   <= ws;
   end

   // Defaults, I2S: frame 512, ws toggles 248/504 cycles into each frame.
   task automatic run_a();
      int s, t0;
      @(negedge clk);
      mode[0] = 1'b0;
      en[0]   = 1'b1;
      s  = cyc + 1;
      t0 = s + 8;
      push(0, EV_BR, s);
      for (int k = 0; k < 3; k++) begin
         push(0, EV_FS,  t0 + 512 * k);
         push(0, EV_WSR, t0 + 512 * k + 248);
         push(0, EV_WSF, t0 + 512 * k + 504);
      end
      push(0, EV_BF, t0 + 1536);
      wait_until(t0);
      for (int i = 0; i < 8; i++) begin
         chk("a_sck",  int'(sck[0]),  int'(i >= 4));
         chk("a_fall", int'(fall[0]), int'(i == 0));
         chk("a_rise", int'(rise[0]), int'(i == 4));
         @(negedge clk);
      end
      wait_until(t0 + 20);
      mode[0] = 1'b1;
      wait_until(t0 + 1034);
      en[0] = 1'b0;
      wait_until(t0 + 1537);
      idle_check("a_idle_after_stop", 0);
   endtask

   // 8 slots x 16 bits, pulse: frame 1024, ws high for the 8 cycles before frame_start.
   task automatic run_b();
      int s, t0;
      @(negedge clk);
      mode[1] = 1'b1;
      en[1]   = 1'b1;
      s  = cyc + 1;
      t0 = s + 8;
      push(1, EV_BR,  s);
      push(1, EV_WSR, s);
      push(1, EV_WSF, t0);
      push(1, EV_FS,  t0);
      push(1, EV_WSR, t0 + 1016);
      push(1, EV_WSF, t0 + 1024);
      push(1, EV_FS,  t0 + 1024);
      push(1, EV_BF,  t0 + 2048);
      wait_until(t0 + 50);
      mode[1] = 1'b0;
      wait_until(t0 + 1034);
      en[1] = 1'b0;
      wait_until(t0 + 2049);
      idle_check("b_idle_after_stop", 1);
   endtask

   // SCK_DIV=2, 4 bits x 2 slots: frame 16, reset mid-frame, restart, stop.
   task automatic run_c();
      int s, t0, t1, s2, t0b;
      @(negedge clk);
      mode[2] = 1'b0;
      en[2]   = 1'b1;
      s  = cyc + 1;
      t0 = s + 2;
      t1 = t0 + 16;
      push(2, EV_BR,  s);
      push(2, EV_FS,  t0);
      push(2, EV_WSR, t0 + 6);
      push(2, EV_WSF, t0 + 14);
      push(2, EV_FS,  t1);
      push(2, EV_WSR, t1 + 6);
      wait_until(s);
      for (int i = 0; i < 8; i++) begin
         chk("c_sck",  int'(sck[2]),  i % 2);
         chk("c_fall", int'(fall[2]), int'(i % 2 == 0));
         chk("c_rise", int'(rise[2]), int'(i % 2 == 1));
         @(negedge clk);
      end
      wait_until(t1 + 8);
      rst_n[2] = 1'b0;
      push(2, EV_WSF, t1 + 9);
      push(2, EV_BF,  t1 + 9);
      @(negedge clk);
      chk("c_reset_outputs", int'({busy[2], sck[2], ws[2], fall[2], rise[2], fs[2]}), 0);
      rst_n[2] = 1'b1;
      s2  = t1 + 10;
      t0b = s2 + 2;
      push(2, EV_BR,  s2);
      push(2, EV_FS,  t0b);
      push(2, EV_WSR, t0b + 6);
      push(2, EV_WSF, t0b + 14);
      push(2, EV_BF,  t0b + 16);
      wait_until(s2);
      chk("c_restart_fall", int'(fall[2]), 1);
      chk("c_restart_sck",  int'(sck[2]),  0);
      wait_until(t0b + 1);
      en[2] = 1'b0;
      wait_until(t0b + 17);
      idle_check("c_idle_after_stop", 2);
   endtask

   initial begin
      rst_n = '0;
      en    = '0;
      mode  = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_sck",  int'(sck),  0);
      chk("reset_ws",   int'(ws),   0);
      chk("reset_fall", int'(fall), 0);
      chk("reset_rise", int'(rise), 0);
      chk("reset_fs",   int'(fs),   0);
      rst_n = '1;
      repeat (2) @(negedge clk);
      chk("idle_outputs", int'({busy, sck, ws, fall, rise, fs}), 0);
      fork
         run_a();
         run_b();
         run_c();
      join
      repeat (5) @(negedge clk);
      chk("dut0_events_left", q0.size(), 0);
      chk("dut1_events_left", q1.size(), 0);
      chk("dut2_events_left", q2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
